// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the big-endian byte-offset to bit-lane mapping.
package dmem_pkg;

    typedef enum logic [1:0] {
        DS_BYTE = 2'b00,
        DS_HALF = 2'b01,
        DS_RSVD = 2'b10,
        DS_WORD = 2'b11
    } dsize_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RD    = 2'b01,
        ST_MERGE = 2'b10
    } state_t;

    // Big-endian: byte offset 0 is the most significant byte of the word.
    localparam logic [4:0] BYTE0_LSB = 5'd24;
    localparam logic [4:0] BYTE1_LSB = 5'd16;
    localparam logic [4:0] BYTE2_LSB = 5'd8;
    localparam logic [4:0] BYTE3_LSB = 5'd0;
    localparam logic [4:0] HALF0_LSB = 5'd16;
    localparam logic [4:0] HALF1_LSB = 5'd0;

    function automatic logic [4:0] byte_lsb(input logic [1:0] offset);
        logic [4:0] lsb;
        case (offset)
            2'd0:    lsb = BYTE0_LSB;
            2'd1:    lsb = BYTE1_LSB;
            2'd2:    lsb = BYTE2_LSB;
            default: lsb = BYTE3_LSB;
        endcase
        return lsb;
    endfunction

    function automatic logic [4:0] half_lsb(input logic half_sel);
        return half_sel ? HALF1_LSB : HALF0_LSB;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: extracts and extends a load lane, and builds the
// read-modify-write word for byte/half stores.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  dsize_t      dsize,
    input  logic        loadext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  lsb;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        lsb       = (dsize == DS_HALF) ? half_lsb(offset[1]) : byte_lsb(offset);
        shifted   = word >> lsb;
        load_data = word;
        mask      = 32'hFFFF_FFFF;
        case (dsize)
            DS_BYTE: begin
                load_data = {{24{loadext & shifted[7]}}, shifted[7:0]};
                mask      = 32'h0000_00FF << lsb;
            end
            DS_HALF: begin
                load_data = {{16{loadext & shifted[15]}}, shifted[15:0]};
                mask      = 32'h0000_FFFF << lsb;
            end
            default: begin
                load_data = word;
                mask      = 32'hFFFF_FFFF;
            end
        endcase
        // Only the low bits of the store data land in the selected lane.
        merge_data = (word & ~mask) | ((wdata << lsb) & mask);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: single-port word RAM, big-endian lanes,
// read-modify-write for sub-word stores and a stall while a read is pending.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 16384,
    parameter int IDX_W     = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [1:0]       dsize,
    input  logic             loadext,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             fault,
    output logic             fault_sticky,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [1:0]         off_reg;
    dsize_t             dsize_reg;
    logic               ext_reg;
    logic [31:0]        wdata_reg;
    logic               sticky_reg;

    dsize_t             req_dsize;
    logic               bad_cond;
    logic               idle_req;
    logic               fault_int;
    logic               accept;
    logic               word_store;
    logic [31:0]        load_data;
    logic [31:0]        merge_data;

    assign req_dsize = dsize_t'(dsize);

    always_comb begin
        bad_cond = (req_dsize == DS_RSVD)
                 | ((req_dsize == DS_HALF) & addr[0])
                 | ((req_dsize == DS_WORD) & (addr[1:0] != 2'b00))
                 | ({1'b0, addr} >= ADDR_LIMIT);
        // Every output is forced low while reset is held, even with req active.
        idle_req   = reset & req & (state_reg == ST_IDLE);
        fault_int  = idle_req & bad_cond;
        accept     = idle_req & ~bad_cond;
        word_store = we & (req_dsize == DS_WORD);
    end

    dmem_lane u_lane (
        .word       (mem_rdata),
        .offset     (off_reg),
        .dsize      (dsize_reg),
        .loadext    (ext_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        stall     = 1'b0;
        rdata     = 32'h0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = idx_reg;
        mem_wdata = 32'h0;
        if (reset) begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        mem_en   = 1'b1;
                        mem_addr = addr[IDX_W+1:2];
                        if (word_store) begin
                            mem_we    = 1'b1;
                            mem_wdata = wdata;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    rdata = load_data;
                end
                ST_MERGE: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = merge_data;
                end
                default: ;
            endcase
        end
    end

    assign fault        = fault_int;
    assign fault_sticky = sticky_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            off_reg    <= 2'b00;
            dsize_reg  <= DS_BYTE;
            ext_reg    <= 1'b0;
            wdata_reg  <= 32'h0;
            sticky_reg <= 1'b0;
        end else begin
            if (fault_int) begin
                sticky_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept && !word_store) begin
                        idx_reg   <= addr[IDX_W+1:2];
                        off_reg   <= addr[1:0];
                        dsize_reg <= req_dsize;
                        ext_reg   <= loadext;
                        wdata_reg <= wdata;
                        state_reg <= we ? ST_MERGE : ST_RD;
                    end
                end
                ST_RD:    state_reg <= ST_IDLE;
                ST_MERGE: state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Table-driven bench for dmem_ctrl with a behavioural sync RAM, a scoreboard
// queue for delayed results, and hand-written reset-abort sequences.
module tb_dmem_ctrl;

    localparam int MEM_WORDS = 16384;
    localparam int IDX_W     = 14;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [31:0]       addr = 32'h0;
    logic [31:0]       wdata = 32'h0;
    logic [1:0]        dsize = 2'b00;
    logic              loadext = 1'b0;
    logic              stall;
    logic [31:0]       rdata;
    logic              fault;
    logic              fault_sticky;
    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] ram [MEM_WORDS];
    int          write_count = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        we;
        logic [1:0]  dsize;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ext;
        logic        flt;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    dmem_ctrl #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .dsize        (dsize),
        .loadext      (loadext),
        .stall        (stall),
        .rdata        (rdata),
        .fault        (fault),
        .fault_sticky (fault_sticky),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                write_count   <= write_count + 1;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] ds, input logic [31:0] a,
                                input logic [31:0] wd, input logic e, input logic f,
                                input logic [31:0] x);
        vec_t v;
        v.we = w; v.dsize = ds; v.addr = a; v.wdata = wd; v.ext = e; v.flt = f; v.exp = x;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},  stall, 0);
        check({tag, "_fault"},  fault, 0);
        check({tag, "_sticky"}, fault_sticky, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_rdata"},  rdata, 0);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [IDX_W-1:0] idx;
        idx = v.addr[IDX_W+1:2];
        @(negedge clock);
        req = 1'b1; we = v.we; dsize = v.dsize; addr = v.addr; wdata = v.wdata; loadext = v.ext;
        #1;
        $display("[TB] vec %0d we=%0b dsize=%b addr=%h wdata=%h ext=%0b", i, v.we, v.dsize, v.addr, v.wdata, v.ext);
        check("fault", fault, v.flt);
        if (v.flt) begin
            check("fault_stall", stall, 0);
            check("fault_mem_en", mem_en, 0);
            check("fault_rdata", rdata, 0);
        end else if (v.we && v.dsize == 2'b11) begin
            check("sw_stall", stall, 0);
            check("sw_mem_en", mem_en, 1);
            check("sw_mem_we", mem_we, 1);
            check("sw_mem_addr", 32'(mem_addr), 32'(idx));
            check("sw_mem_wdata", mem_wdata, v.exp);
        end else begin
            int n;
            check("issue_stall", stall, 1);
            check("issue_mem_en", mem_en, 1);
            check("issue_mem_we", mem_we, 0);
            check("issue_rdata", rdata, 0);
            exp_q.push_back(v.exp);
            // Disturb the request fields; the captured copies must be used.
            @(negedge clock);
            addr = 32'hFFFF_FFF1; wdata = 32'h5555_5555; dsize = 2'b10; loadext = ~v.ext;
            #1;
            n = 0;
            while (stall && n < 4) begin
                @(negedge clock);
                #1;
                n++;
            end
            check("stall_release", stall, 0);
            check("ignored_fault", fault, 0);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else if (v.we) begin
                check("merge_mem_en", mem_en, 1);
                check("merge_mem_we", mem_we, 1);
                check("merge_mem_addr", 32'(mem_addr), 32'(idx));
                check("merge_mem_wdata", mem_wdata, exp_q.pop_front());
            end else begin
                check("rd_mem_en", mem_en, 0);
                check("rd_rdata", rdata, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        int wc;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'h0;
        ram[1]           = 32'h8899_AABB;
        ram[MEM_WORDS-1] = 32'hDEAD_BEEF;
        mem_rdata        = 32'h0;

        vecs[0]  = mk(0, 2'b00, 32'h5,     32'h0,         1, 0, 32'hFFFF_FF99);
        vecs[1]  = mk(0, 2'b01, 32'h6,     32'h0,         0, 0, 32'h0000_AABB);
        vecs[2]  = mk(0, 2'b11, 32'h4,     32'h0,         0, 0, 32'h8899_AABB);
        vecs[3]  = mk(0, 2'b00, 32'h7,     32'h0,         0, 0, 32'h0000_00BB);
        vecs[4]  = mk(0, 2'b01, 32'h4,     32'h0,         1, 0, 32'hFFFF_8899);
        vecs[5]  = mk(1, 2'b00, 32'h4,     32'h0000_00CC, 0, 0, 32'hCC99_AABB);
        vecs[6]  = mk(0, 2'b11, 32'h4,     32'h0,         0, 0, 32'hCC99_AABB);
        vecs[7]  = mk(1, 2'b01, 32'h6,     32'hABCD_1234, 0, 0, 32'hCC99_1234);
        vecs[8]  = mk(0, 2'b00, 32'h6,     32'h0,         1, 0, 32'h0000_0012);
        vecs[9]  = mk(1, 2'b11, 32'h8,     32'h1234_5678, 0, 0, 32'h1234_5678);
        vecs[10] = mk(0, 2'b11, 32'h8,     32'h0,         0, 0, 32'h1234_5678);
        vecs[11] = mk(0, 2'b01, 32'h3,     32'h0,         0, 1, 32'h0);
        vecs[12] = mk(0, 2'b11, 32'h10000, 32'h0,         0, 1, 32'h0);
        vecs[13] = mk(0, 2'b10, 32'h4,     32'h0,         0, 1, 32'h0);
        vecs[14] = mk(1, 2'b00, 32'h7,     32'hFFFF_FF5A, 0, 0, 32'hCC99_125A);
        vecs[15] = mk(0, 2'b11, 32'h4,     32'h0,         0, 0, 32'hCC99_125A);
        vecs[16] = mk(0, 2'b11, 32'hFFFC,  32'h0,         0, 0, 32'hDEAD_BEEF);
        vecs[17] = mk(1, 2'b11, 32'h3,     32'h1111_1111, 0, 1, 32'h0);

        // Reset held with an active load request: everything must stay low.
        req = 1'b1; we = 1'b0; dsize = 2'b11; addr = 32'h4;
        #12;
        check_reset_outputs("por");
        req = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i <= 10; i++) run_vec(i, vecs[i]);
        @(negedge clock);
        req = 1'b0;
        #1;
        check("sticky_before_fault", fault_sticky, 0);
        for (int i = 11; i < NVEC; i++) run_vec(i, vecs[i]);
        @(negedge clock);
        req = 1'b0;
        #1;
        check("sticky_set", fault_sticky, 1);
        @(negedge clock);
        #1;
        check("sticky_held", fault_sticky, 1);
        check("ram_word2", ram[2], 32'h1234_5678);

        // Abort a load while in RD.
        @(negedge clock);
        req = 1'b1; we = 1'b0; dsize = 2'b11; addr = 32'h4; loadext = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        $display("[TB] reset during RD");
        check_reset_outputs("rst_rd");
        @(negedge clock);
        req = 1'b0;
        reset = 1'b1;

        // Abort a byte store while in MERGE; no write may reach the RAM.
        wc = write_count;
        @(negedge clock);
        req = 1'b1; we = 1'b1; dsize = 2'b00; addr = 32'h4; wdata = 32'h0000_0077;
        @(negedge clock);
        reset = 1'b0;
        req = 1'b0;
        #1;
        $display("[TB] reset during MERGE");
        check_reset_outputs("rst_merge");
        @(posedge clock);
        #1;
        check("rst_merge_no_write", 32'(write_count), 32'(wc));
        check("rst_merge_ram", ram[1], 32'hCC99_125A);
        @(negedge clock);
        reset = 1'b1;

        run_vec(100, mk(0, 2'b11, 32'h4, 32'h0, 0, 0, 32'hCC99_125A));
        @(negedge clock);
        req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory access controller between the core's ALU/store-data path and a single-port, word-wide synchronous data RAM. It takes the effective address (ALU result), store data (busB) and the size/extension controls from CTRL. It performs big-endian byte-lane extraction with sign/zero extension on loads, and read-modify-write on byte and half stores. It raises a stall so the single-cycle core holds while a memory access is outstanding.

Parameters:
MEM_WORDS, 16384, RAM depth in 32-bit words.
IDX_W, 14, word-index width; must equal clog2(MEM_WORDS).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  1  core requests a data access this cycle.
we  in  1  1 = store, 0 = load.
addr  in  32  byte address (alu_out).
wdata  in  32  store data, right-justified (busB).
dsize  in  2  00 byte, 01 half, 11 word, 10 reserved.
loadext  in  1  load extension: 1 = sign, 0 = zero.
stall  out  1  core must hold its PC and request fields.
rdata  out  32  formatted load data.
fault  out  1  current request is misaligned, out of range or reserved-size.
fault_sticky  out  1  latched fault; cleared only by reset.
mem_en  out  1  RAM enable.
mem_we  out  1  RAM write enable.
mem_addr  out  IDX_W  RAM word index.
mem_wdata  out  32  RAM write word.
mem_rdata  in  32  RAM read word, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Byte order is big-endian. Byte offset 0 maps to bits 31:24 and offset 3 to bits 7:0. Half offset 0 maps to bits 31:16.
- Word index is addr[IDX_W+1:2].
- fault is combinational and applies to the request in the IDLE state. It is set when any of these hold:
  - dsize==10;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr >= MEM_WORDS*4.
- A faulting request:
  - makes no RAM access;
  - gives stall=0 and rdata=0;
  - sets fault_sticky at the next edge.
- FSM states are IDLE, RD, MERGE.
- IDLE, store word (req & we & dsize==11, no fault):
  - mem_en=1, mem_we=1, mem_wdata=wdata in the same cycle;
  - stall=0; stays in IDLE.
- IDLE, load (req & !we, no fault):
  - mem_en=1, mem_we=0, stall=1;
  - capture offset, dsize and loadext; go to RD.
- IDLE, byte or half store (no fault):
  - issue a read, stall=1;
  - capture index, offset, dsize and wdata; go to MERGE.
- RD:
  - rdata = extracted lane of mem_rdata, extended per captured loadext (combinational);
  - stall=0; return to IDLE.
  - Load latency: stall is high for one cycle, and data is valid in the second cycle.
- MERGE:
  - mem_en=1, mem_we=1 at the captured index;
  - mem_wdata = mem_rdata with the selected lane replaced by the low bits of captured wdata;
  - stall=0; return to IDLE.
- Captured fields are used in RD and MERGE. Changes on req, addr and wdata during RD or MERGE are ignored.
- A new request is accepted only in IDLE, so back-to-back non-word accesses have one turnaround cycle.
- Outside the cases above, mem_en=0, mem_we=0 and rdata=0.
- Reset (async, reset=0):
  - state goes to IDLE and captured fields clear;
  - all outputs are 0 while reset is asserted, including stall, fault, fault_sticky, mem_en and mem_we;
  - an in-flight read or merge is abandoned and no partial write is issued.

Decomposition:
- Package dmem_pkg holds:
  - dsize encodings (DS_BYTE, DS_HALF, DS_WORD, DS_RSVD);
  - the state enum;
  - the byte-offset-to-lane mapping constants.
- One natural sub-module, dmem_lane, is purely combinational:
  - load lane extract and extend;
  - store lane merge.
- dmem_lane is shared by the RD and MERGE paths. The FSM, capture registers and fault logic stay in dmem_ctrl.

Test Plan:
1. Preload word index 1 = 0x8899AABB. Load byte, addr 0x5, loadext=1 -> stall=1 for one cycle, then rdata=0xFFFFFF99 with stall=0.
2. Same word, load half, addr 0x6, loadext=0 -> rdata=0x0000AABB. Load word at addr 0x4 -> 0x8899AABB.
3. Store byte, addr 0x4, wdata=0x000000CC -> read cycle, then mem_we in MERGE with mem_wdata=0xCC99AABB. Reading the word back returns 0xCC99AABB.
4. Store word, addr 0x8, wdata=0x12345678 -> mem_en=mem_we=1 in the same cycle with stall=0. A following load word of 0x8 returns 0x12345678.
5. Load half at addr 0x3, then load word at addr 0x10000 -> fault=1 each time, mem_en=0, stall=0, rdata=0; fault_sticky=1 and remains set.
6. Assert reset=0 during RD of a load, and separately during MERGE of a byte store -> immediate IDLE with all outputs 0 and no RAM write. After release, a load of index 1 returns the original value.
